// File: rtl/axis_rgb888_pixel_packer.sv
// RGB888 AXI4-Stream to 32-bit word packer: XBGR32, XRGB32, packed RGB565, packed RGB24.
// Residual bytes of packed modes are flushed PAD-filled at line end; mode switches only on SOF beats.
`timescale 1ns/1ps
module axis_rgb888_pixel_packer #(
    parameter logic [7:0]  ALPHA_VALUE   = 8'h00,
    parameter logic [7:0]  PAD_VALUE     = 8'h00,
    parameter int unsigned ENABLE_PACKED = 1
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [1:0]  cfg_mode,
    input  logic [23:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic [1:0]  active_mode,
    output logic        sts_drop
);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t      state_q, state_d;
    logic [23:0] res_q, res_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  mode_q, mode_d;
    logic        pend_q, pend_d;
    logic        en_q;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        last_q, last_d;
    logic        user_q, user_d;
    logic        drop_q, drop_d;

    logic        out_free, accept, packed_mode, mode_565, mode_bgr, sof_drop, emit_full;
    logic [1:0]  eff_mode, base_cnt;
    logic [23:0] base_res, new_bytes;
    logic [15:0] pix565;
    logic [2:0]  nbytes, total;
    logic [47:0] comb;
    logic [7:0]  pr, pg, pb;

    function automatic logic [31:0] pad_word(input logic [23:0] d, input logic [2:0] n);
        logic [31:0] dx;
        logic [31:0] w;
        dx = {8'h00, d};
        w  = '0;
        for (int unsigned i = 0; i < 4; i++)
            w[i*8 +: 8] = (i < 32'(n)) ? dx[i*8 +: 8] : PAD_VALUE;
        return w;
    endfunction

    assign {pr, pg, pb}  = s_axis_tdata;
    // Ready stays low while areset is high and for one cycle after release.
    assign out_free      = !valid_q || m_axis_tready;
    assign s_axis_tready = en_q && (state_q == RUN) && out_free;
    assign accept        = s_axis_tvalid && s_axis_tready;

    assign eff_mode    = s_axis_tuser ? cfg_mode : mode_q;
    assign packed_mode = (ENABLE_PACKED != 0) && eff_mode[1];
    assign mode_bgr    = !eff_mode[1] && eff_mode[0];
    assign mode_565    = !eff_mode[0];
    assign sof_drop    = accept && s_axis_tuser && (cnt_q != 2'd0);
    assign base_cnt    = sof_drop ? 2'd0 : cnt_q;
    assign base_res    = sof_drop ? '0 : res_q;
    assign pix565      = {pr[7:3], pg[7:2], pb[7:3]};
    assign new_bytes   = mode_565 ? {8'h00, pix565} : {pr, pg, pb};
    assign nbytes      = mode_565 ? 3'd2 : 3'd3;
    // New bytes land above the residual, so word byte order equals stream order.
    assign comb        = {24'd0, base_res} | ({24'd0, new_bytes} << {base_cnt, 3'b000});
    assign total       = {1'b0, base_cnt} + nbytes;
    assign emit_full   = total[2];

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        pend_d  = pend_q;
        data_d  = data_q;
        valid_d = valid_q && !m_axis_tready;
        last_d  = last_q;
        user_d  = user_q;
        drop_d  = 1'b0;

        if (state_q == FLUSH) begin
            if (out_free) begin
                valid_d = 1'b1;
                data_d  = pad_word(res_q, {1'b0, cnt_q});
                last_d  = 1'b1;
                user_d  = pend_q;
                pend_d  = 1'b0;
                res_d   = '0;
                cnt_d   = '0;
                state_d = RUN;
            end
        end else if (accept) begin
            if (s_axis_tuser)
                mode_d = cfg_mode;
            drop_d = sof_drop;
            if (!packed_mode) begin
                valid_d = 1'b1;
                data_d  = mode_bgr ? {ALPHA_VALUE, pb, pg, pr} : {ALPHA_VALUE, pr, pg, pb};
                last_d  = s_axis_tlast;
                user_d  = pend_q || s_axis_tuser;
                pend_d  = 1'b0;
                res_d   = '0;
                cnt_d   = '0;
            end else if (emit_full) begin
                valid_d = 1'b1;
                data_d  = comb[31:0];
                user_d  = pend_q || s_axis_tuser;
                pend_d  = 1'b0;
                res_d   = {8'h00, comb[47:32]};
                cnt_d   = total[1:0];
                if (s_axis_tlast && (total[1:0] != 2'd0)) begin
                    last_d  = 1'b0;
                    state_d = FLUSH;
                end else begin
                    last_d  = s_axis_tlast;
                end
            end else if (s_axis_tlast) begin
                valid_d = 1'b1;
                data_d  = pad_word(comb[23:0], total);
                last_d  = 1'b1;
                user_d  = pend_q || s_axis_tuser;
                pend_d  = 1'b0;
                res_d   = '0;
                cnt_d   = '0;
            end else begin
                res_d  = comb[23:0];
                cnt_d  = total[1:0];
                pend_d = pend_q || s_axis_tuser;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= RUN;
            res_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= '0;
            pend_q  <= 1'b0;
            en_q    <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            user_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            pend_q  <= pend_d;
            en_q    <= 1'b1;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            user_q  <= user_d;
            drop_q  <= drop_d;
        end
    end

    assign m_axis_tdata  = data_q;
    assign m_axis_tvalid = valid_q;
    assign m_axis_tlast  = last_q;
    assign m_axis_tuser  = user_q;
    assign active_mode   = mode_q;
    assign sts_drop      = drop_q;

endmodule

// File: tb/tb_axis_rgb888_pixel_packer.sv
// Bench for axis_rgb888_pixel_packer: byte-queue reference model plus directed line/frame scenarios.
`timescale 1ns/1ps
module tb_axis_rgb888_pixel_packer;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [1:0]  cfg_mode = 2'd0;
    logic [23:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tuser = 1'b0;
    logic        m_axis_tready = 1'b1;
    logic        s_axis_tready, s_ready_b;
    logic [31:0] m_axis_tdata, m_tdata_b;
    logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser;
    logic        m_valid_b, m_last_b, m_user_b;
    logic [1:0]  active_mode, active_mode_b;
    logic        sts_drop, sts_drop_b;

    always #5 aclk = ~aclk;

    axis_rgb888_pixel_packer #(.ALPHA_VALUE(8'h00), .PAD_VALUE(8'h00), .ENABLE_PACKED(1)) dut (
        .aclk(aclk), .areset(areset), .cfg_mode(cfg_mode),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .active_mode(active_mode), .sts_drop(sts_drop)
    );

    axis_rgb888_pixel_packer #(.ALPHA_VALUE(8'hFF), .PAD_VALUE(8'h00), .ENABLE_PACKED(1)) dut_ff (
        .aclk(aclk), .areset(areset), .cfg_mode(cfg_mode),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_ready_b),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_tdata_b), .m_axis_tvalid(m_valid_b), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_last_b), .m_axis_tuser(m_user_b),
        .active_mode(active_mode_b), .sts_drop(sts_drop_b)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        user;
        logic        am;
    } exp_t;

    exp_t        expq[$];
    logic [7:0]  bq[$];
    logic [31:0] got_d[$];
    logic        got_l[$];
    logic        got_u[$];
    logic [1:0]  mode_m = 2'd0;
    logic        pend_m = 1'b0, drop_exp = 1'b0, word_next = 1'b0;
    int          checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic void push_exp(input logic [31:0] d, input logic l, input logic am);
        exp_t e;
        e.data = d;
        e.last = l;
        e.user = pend_m;
        e.am   = am;
        pend_m = 1'b0;
        expq.push_back(e);
    endfunction

    // Reference model: compare current outputs, then absorb the beat accepted at the next edge.
    always @(negedge aclk) begin : model
        logic [7:0]  r, g, b;
        logic [15:0] p;
        logic [31:0] w;
        exp_t        e;
        int          nw;
        if (areset) begin
            expq.delete();
            bq.delete();
            mode_m    = 2'd0;
            pend_m    = 1'b0;
            drop_exp  = 1'b0;
            word_next = 1'b0;
        end else begin
            chk("sts_drop", 32'(sts_drop), 32'(drop_exp));
            chk("active_mode", 32'(active_mode), 32'(mode_m));
            if (word_next)
                chk("latency_valid", 32'(m_axis_tvalid), 32'd1);
            if (m_axis_tvalid && !m_axis_tready)
                chk("s_ready_backpressure", 32'(s_axis_tready), 32'd0);
            if (m_axis_tvalid) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual=0x%08h required=no word t=%0t", m_axis_tdata, $time);
                end else begin
                    e = expq[0];
                    chk("m_tdata", m_axis_tdata, e.data);
                    chk("m_tlast", 32'(m_axis_tlast), 32'(e.last));
                    chk("m_tuser", 32'(m_axis_tuser), 32'(e.user));
                    chk("m_tdata_alpha_ff", m_tdata_b, e.am ? {8'hFF, e.data[23:0]} : e.data);
                    if (m_axis_tready) begin
                        got_d.push_back(m_axis_tdata);
                        got_l.push_back(m_axis_tlast);
                        got_u.push_back(m_axis_tuser);
                        void'(expq.pop_front());
                    end
                end
            end

            drop_exp  = 1'b0;
            word_next = 1'b0;
            if (s_axis_tvalid && s_axis_tready) begin
                if (s_axis_tuser) begin
                    mode_m = cfg_mode;
                    pend_m = 1'b1;
                    if (bq.size() != 0) begin
                        bq.delete();
                        drop_exp = 1'b1;
                    end
                end
                {r, g, b} = s_axis_tdata;
                nw = 0;
                if (mode_m < 2'd2) begin
                    push_exp((mode_m == 2'd1) ? {8'h00, b, g, r} : {8'h00, r, g, b}, s_axis_tlast, 1'b1);
                    nw++;
                end else begin
                    if (mode_m == 2'd2) begin
                        p = {r[7:3], g[7:2], b[7:3]};
                        bq.push_back(p[7:0]);
                        bq.push_back(p[15:8]);
                    end else begin
                        bq.push_back(b);
                        bq.push_back(g);
                        bq.push_back(r);
                    end
                    while (bq.size() >= 4) begin
                        w = {bq[3], bq[2], bq[1], bq[0]};
                        repeat (4) void'(bq.pop_front());
                        push_exp(w, s_axis_tlast && (bq.size() == 0), 1'b0);
                        nw++;
                    end
                    if (s_axis_tlast && (bq.size() != 0)) begin
                        w = '0;
                        for (int i = 0; i < bq.size(); i++)
                            w[i*8 +: 8] = bq[i];
                        bq.delete();
                        push_exp(w, 1'b1, 1'b0);
                        nw++;
                    end
                end
                word_next = (nw != 0);
            end
        end
    end

    task automatic send(input logic [23:0] d, input logic l, input logic u);
        int unsigned n;
        n = 0;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tuser  = u;
        s_axis_tvalid = 1'b1;
        @(negedge aclk);
        while (!s_axis_tready && n < 100) begin
            @(negedge aclk);
            n++;
        end
        if (!s_axis_tready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=ready low required=ready within 100 cycles t=%0t", $time);
        end
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic lit(input string name, input int idx, input logic [31:0] d, input logic l, input logic u);
        if (idx >= got_d.size()) begin
            checks++;
            errors++;
            $display("FAIL %s actual=missing word required=0x%08h", name, d);
        end else begin
            chk(name, got_d[idx], d);
            chk({name, "_last"}, 32'(got_l[idx]), 32'(l));
            chk({name, "_user"}, 32'(got_u[idx]), 32'(u));
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_m_tvalid"}, 32'(m_axis_tvalid), 32'd0);
        chk({tag, "_m_tdata"}, m_axis_tdata, 32'd0);
        chk({tag, "_m_tlast"}, 32'(m_axis_tlast), 32'd0);
        chk({tag, "_m_tuser"}, 32'(m_axis_tuser), 32'd0);
        chk({tag, "_active_mode"}, 32'(active_mode), 32'd0);
        chk({tag, "_sts_drop"}, 32'(sts_drop), 32'd0);
        chk({tag, "_s_tready"}, 32'(s_axis_tready), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        repeat (3) @(posedge aclk);
        #1;
        chk_reset_outputs("reset");
        areset = 1'b0;

        // Mode 0, four pixels with SOF and EOL
        cfg_mode = 2'd0;
        base = got_d.size();
        send(24'h112233, 1'b0, 1'b1);
        chk("t1_latency_valid", 32'(m_axis_tvalid), 32'd1);
        chk("t1_latency_data", m_axis_tdata, 32'h00112233);
        send(24'h445566, 1'b0, 1'b0);
        send(24'h778899, 1'b0, 1'b0);
        send(24'hAABBCC, 1'b1, 1'b0);
        idle(3);
        lit("t1_w0", base + 0, 32'h00112233, 1'b0, 1'b1);
        lit("t1_w1", base + 1, 32'h00445566, 1'b0, 1'b0);
        lit("t1_w2", base + 2, 32'h00778899, 1'b0, 1'b0);
        lit("t1_w3", base + 3, 32'h00AABBCC, 1'b1, 1'b0);

        // Mode 1 with output stalled for five cycles
        cfg_mode = 2'd1;
        m_axis_tready = 1'b0;
        base = got_d.size();
        send(24'h112233, 1'b1, 1'b1);
        repeat (5) begin
            @(negedge aclk);
            chk("t2_hold_data_ff", m_tdata_b, 32'hFF332211);
            chk("t2_hold_valid", 32'(m_axis_tvalid), 32'd1);
            chk("t2_hold_s_tready", 32'(s_axis_tready), 32'd0);
        end
        @(posedge aclk);
        #1;
        m_axis_tready = 1'b1;
        idle(2);
        lit("t2_w0", base, 32'h00332211, 1'b1, 1'b1);

        // Mode 2, odd pixel count flushes a half word
        cfg_mode = 2'd2;
        base = got_d.size();
        send(24'hFF0000, 1'b0, 1'b1);
        send(24'h00FF00, 1'b0, 1'b0);
        send(24'h0000FF, 1'b1, 1'b0);
        idle(3);
        lit("t3_w0", base + 0, 32'h07E0F800, 1'b0, 1'b1);
        lit("t3_w1", base + 1, 32'h0000001F, 1'b1, 1'b0);

        // Mode 3, six pixels: residual of two bytes forces a one-cycle flush
        cfg_mode = 2'd3;
        base = got_d.size();
        send(24'h010203, 1'b0, 1'b1);
        send(24'h040506, 1'b0, 1'b0);
        send(24'h070809, 1'b0, 1'b0);
        send(24'h0A0B0C, 1'b0, 1'b0);
        send(24'h0D0E0F, 1'b0, 1'b0);
        send(24'h101112, 1'b1, 1'b0);
        chk("t4_flush_s_tready_low", 32'(s_axis_tready), 32'd0);
        @(posedge aclk);
        #1;
        chk("t4_flush_s_tready_back", 32'(s_axis_tready), 32'd1);
        idle(3);
        lit("t4_w0", base + 0, 32'h06010203, 1'b0, 1'b1);
        lit("t4_w1", base + 1, 32'h08090405, 1'b0, 1'b0);
        lit("t4_w2", base + 2, 32'h0A0B0C07, 1'b0, 1'b0);
        lit("t4_w3", base + 3, 32'h120D0E0F, 1'b0, 1'b0);
        lit("t4_w4", base + 4, 32'h00001011, 1'b1, 1'b0);

        // cfg_mode change mid-line takes effect only on the next SOF beat
        cfg_mode = 2'd0;
        base = got_d.size();
        send(24'h123456, 1'b0, 1'b1);
        cfg_mode = 2'd3;
        send(24'h654321, 1'b0, 1'b0);
        chk("t5_mode_unchanged", 32'(active_mode), 32'd0);
        send(24'h0A0B0C, 1'b1, 1'b0);
        send(24'h010203, 1'b0, 1'b1);
        chk("t5_mode_switched", 32'(active_mode), 32'd3);
        send(24'h040506, 1'b1, 1'b0);
        idle(4);
        lit("t5_w0", base + 0, 32'h00123456, 1'b0, 1'b1);
        lit("t5_w1", base + 1, 32'h00654321, 1'b0, 1'b0);
        lit("t5_w2", base + 2, 32'h000A0B0C, 1'b1, 1'b0);
        lit("t5_w3", base + 3, 32'h06010203, 1'b0, 1'b1);
        lit("t5_w4", base + 4, 32'h00000405, 1'b1, 1'b0);

        // Residual dropped at SOF, then reset with a word held
        cfg_mode = 2'd3;
        send(24'h112233, 1'b0, 1'b1);
        send(24'h445566, 1'b0, 1'b1);
        chk("t6_drop_pulse", 32'(sts_drop), 32'd1);
        chk("t6_drop_no_word", 32'(m_axis_tvalid), 32'd0);
        @(posedge aclk);
        #1;
        chk("t6_drop_clear", 32'(sts_drop), 32'd0);
        m_axis_tready = 1'b0;
        send(24'h778899, 1'b0, 1'b0);
        chk("t6_held_word", m_axis_tdata, 32'h99445566);
        @(negedge aclk);
        #2;
        areset = 1'b1;
        #1;
        chk_reset_outputs("t6_async_reset");
        @(posedge aclk);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        m_axis_tready = 1'b1;
        base = got_d.size();
        send(24'h0C0D0E, 1'b1, 1'b0);
        idle(3);
        lit("t6_post_reset_mode0", base, 32'h000C0D0E, 1'b1, 1'b0);
        chk("t6_post_reset_mode", 32'(active_mode), 32'd0);

        chk("model_queue_empty", 32'(expq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
